// File: rtl/control_rx_pkg.sv
// Shared word-type codes, FSM encoding and buffer sizing for the receive-write path.
package control_rx_pkg;

    localparam int MAX_WORDS = 128;

    localparam logic [1:0] WT_MID    = 2'b00;
    localparam logic [1:0] WT_FIRST  = 2'b01;
    localparam logic [1:0] WT_LAST   = 2'b10;
    localparam logic [1:0] WT_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DISC  = 2'd3
    } rx_state_e;

    function automatic logic [1:0] word_type(input logic first, input logic last);
        logic [1:0] t;
        case ({first, last})
            2'b11:   t = WT_SINGLE;
            2'b10:   t = WT_FIRST;
            2'b01:   t = WT_LAST;
            default: t = WT_MID;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_rx_byte_pack.sv
// Packs a byte stream big-endian into 134-bit words; a full word waits in the
// accumulator until the next byte (middle word) or the flush (last word).
module control_rx_byte_pack #(
    parameter int WORDS = 128
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   iv_byte,
    input  logic         i_start,
    input  logic         i_byte_en,
    input  logic         i_flush,
    output logic [133:0] ov_word,
    output logic         o_word_wr,
    output logic [6:0]   ov_widx,
    output logic         o_full
);
    import control_rx_pkg::*;

    logic [127:0] acc_q;
    logic [127:0] acc_ins;
    logic [4:0]   cnt_q;
    logic [6:0]   widx_q;
    logic         first_q;
    logic         emit_mid;
    logic         emit;
    logic [3:0]   unused;

    assign emit_mid = i_byte_en && (cnt_q == 5'd16);
    assign emit     = emit_mid || i_flush;
    assign unused   = 4'(5'd16 - cnt_q);
    // Accepting another byte now would need a word beyond the buffer.
    assign o_full   = (cnt_q == 5'd16) && (widx_q == 7'(WORDS - 1));

    always_comb begin
        acc_ins = acc_q;
        for (int i = 0; i < 16; i++) begin
            if (cnt_q == 5'(i)) acc_ins[127 - 8*i -: 8] = iv_byte;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            widx_q    <= '0;
            first_q   <= 1'b0;
            ov_word   <= '0;
            o_word_wr <= 1'b0;
            ov_widx   <= '0;
        end else begin
            o_word_wr <= emit;
            if (emit) begin
                ov_word <= {word_type(first_q, i_flush), (i_flush ? unused : 4'd0), acc_q};
                ov_widx <= widx_q;
                widx_q  <= widx_q + 7'd1;
                first_q <= 1'b0;
            end
            if (i_start) begin
                acc_q   <= {iv_byte, 120'd0};
                cnt_q   <= 5'd1;
                widx_q  <= '0;
                first_q <= 1'b1;
            end else if (emit_mid) begin
                acc_q <= {iv_byte, 120'd0};
                cnt_q <= 5'd1;
            end else if (i_byte_en) begin
                acc_q <= acc_ins;
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

endmodule

// File: rtl/control_rx_write.sv
// Receive-side frame writer: bufid handshake, frame FSM and 1-deep descriptor slot.
// Define CONTROL_RX_DEBUG_EN to build the delivered/dropped frame counters.
module control_rx_write #(
    parameter logic [4:0] INPORT    = 5'd0,
    parameter int         MAX_WORDS = control_rx_pkg::MAX_WORDS
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   iv_data,
    input  logic         i_data_wr,
    output logic         o_pkt_bufid_req,
    input  logic [8:0]   iv_pkt_bufid,
    input  logic         i_pkt_bufid_wr,
    output logic [133:0] ov_pkt_data,
    output logic         o_pkt_data_wr,
    output logic [15:0]  ov_pkt_waddr,
    output logic [8:0]   ov_pkt_bufid_free,
    output logic         o_pkt_bufid_free_wr,
    output logic [13:0]  ov_pkt_descriptor,
    output logic         o_pkt_descriptor_wr,
    input  logic         i_pkt_descriptor_ready,
    output logic [15:0]  ov_debug_rx_cnt,
    output logic [15:0]  ov_debug_drop_cnt
);
    import control_rx_pkg::*;

    rx_state_e   state_q;
    logic        prev_wr_q;
    logic        held_q;
    logic        held_d;
    logic [8:0]  bufid_q;
    logic [8:0]  frame_bufid_q;
    logic        req_q;
    logic        free_wr_q;
    logic [8:0]  free_bufid_q;
    logic        desc_wr_q;
    logic [13:0] desc_q;

    logic        start;
    logic        accept;
    logic        pk_byte;
    logic        pk_flush;
    logic        pk_full;
    logic        overflow;
    logic        done_ev;
    logic [6:0]  pk_widx;

    // prev_wr_q resets high so a frame already running at reset release is never seen as a start.
    assign start    = i_data_wr && !prev_wr_q;
    assign accept   = (state_q == ST_IDLE) && start && held_q && !desc_wr_q;
    assign pk_byte  = (state_q == ST_RECV) && i_data_wr;
    assign pk_flush = (state_q == ST_RECV) && !i_data_wr;
    assign overflow = pk_byte && pk_full;
    assign done_ev  = (state_q == ST_FLUSH);

    always_comb begin
        held_d = held_q;
        if (accept) held_d = 1'b0;
        else if (!held_q && i_pkt_bufid_wr) held_d = 1'b1;
    end

    control_rx_byte_pack #(
        .WORDS(MAX_WORDS)
    ) u_pack (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .iv_byte   (iv_data),
        .i_start   (accept),
        .i_byte_en (pk_byte),
        .i_flush   (pk_flush),
        .ov_word   (ov_pkt_data),
        .o_word_wr (o_pkt_data_wr),
        .ov_widx   (pk_widx),
        .o_full    (pk_full)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            prev_wr_q     <= 1'b1;
            held_q        <= 1'b0;
            bufid_q       <= '0;
            frame_bufid_q <= '0;
            req_q         <= 1'b0;
            free_wr_q     <= 1'b0;
            free_bufid_q  <= '0;
            desc_wr_q     <= 1'b0;
            desc_q        <= '0;
        end else begin
            prev_wr_q <= i_data_wr;
            held_q    <= held_d;
            req_q     <= !held_d;
            free_wr_q <= 1'b0;
            if (!held_q && i_pkt_bufid_wr) bufid_q <= iv_pkt_bufid;
            if (accept) frame_bufid_q <= bufid_q;
            if (overflow) begin
                free_wr_q    <= 1'b1;
                free_bufid_q <= frame_bufid_q;
            end
            if (done_ev) begin
                desc_wr_q <= 1'b1;
                desc_q    <= {INPORT, frame_bufid_q};
            end else if (i_pkt_descriptor_ready) begin
                desc_wr_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE:  if (accept) state_q <= ST_RECV;
                          else if (start) state_q <= ST_DISC;
                ST_RECV:  if (overflow) state_q <= ST_DISC;
                          else if (!i_data_wr) state_q <= ST_FLUSH;
                ST_FLUSH: state_q <= ST_IDLE;
                ST_DISC:  if (!i_data_wr) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_pkt_bufid_req     = req_q;
    assign ov_pkt_waddr        = {frame_bufid_q, pk_widx};
    assign ov_pkt_bufid_free   = free_bufid_q;
    assign o_pkt_bufid_free_wr = free_wr_q;
    assign ov_pkt_descriptor   = desc_q;
    assign o_pkt_descriptor_wr = desc_wr_q;

`ifdef CONTROL_RX_DEBUG_EN
    logic        drop_ev;
    logic [15:0] rx_cnt_q;
    logic [15:0] drop_cnt_q;

    assign drop_ev = ((state_q == ST_IDLE) && start && !accept) || overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (done_ev) rx_cnt_q <= rx_cnt_q + 16'd1;
            if (drop_ev) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign ov_debug_rx_cnt   = rx_cnt_q;
    assign ov_debug_drop_cnt = drop_cnt_q;
`else
    assign ov_debug_rx_cnt   = 16'd0;
    assign ov_debug_drop_cnt = 16'd0;
`endif

endmodule

// File: doc/control_rx_write.md
CONTROL_RX_WRITE -- requirements
Module: control_rx_write

Interface
REQ-001 SHALL have parameter INPORT, default 5'd0: input port number placed in descriptor [13:9].
REQ-002 SHALL have parameter MAX_WORDS, default 128: buffer words per bufid (2048 bytes).
REQ-003 SHALL have ports, clock and reset first:
- i_clk  in  1  single clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- iv_data  in  8  received byte.
- i_data_wr  in  1  byte valid; a frame is one contiguous run of i_data_wr high.
- o_pkt_bufid_req  out  1  free bufid wanted.
- iv_pkt_bufid  in  9  free bufid from PCB.
- i_pkt_bufid_wr  in  1  bufid valid pulse.
- ov_pkt_data  out  134  word to PCB.
- o_pkt_data_wr  out  1  word valid.
- ov_pkt_waddr  out  16  {bufid, word index[6:0]}.
- ov_pkt_bufid_free  out  9  bufid returned on error.
- o_pkt_bufid_free_wr  out  1  return pulse.
- ov_pkt_descriptor  out  14  {INPORT, bufid}.
- o_pkt_descriptor_wr  out  1  descriptor valid, held until accepted.
- i_pkt_descriptor_ready  in  1  consumer accepts when high with valid.
- ov_debug_rx_cnt  out  16  frames delivered.
- ov_debug_drop_cnt  out  16  frames dropped.

Function
REQ-004 SHALL pack bytes big-endian: first byte of a word at [127:120], 16th at [7:0].
REQ-005 SHALL set [133:132] = 01 first word, 00 middle, 10 last, 11 single-word frame; [131:128] = unused byte count of last word (0..15), 0 otherwise; unused bytes zero.
REQ-006 SHALL hold each completed word in a pending register until the next byte arrives (written as non-last) or i_data_wr falls (written as last).
REQ-007 SHALL write the last word in the cycle after the first i_data_wr-low cycle; descriptor valid asserts the following cycle.
REQ-008 SHALL use FSM states IDLE, RECV, FLUSH, DISC: IDLE->RECV on i_data_wr with bufid held and descriptor slot free; IDLE->DISC on i_data_wr otherwise; RECV->FLUSH on i_data_wr low; FLUSH->IDLE after last write; DISC->IDLE on i_data_wr low.
REQ-009 SHALL assert o_pkt_bufid_req while no bufid is held and latch iv_pkt_bufid on i_pkt_bufid_wr; i_pkt_bufid_wr while a bufid is held is ignored.
REQ-010 SHALL consume the held bufid when a frame enters RECV.
REQ-011 SHALL hold a 1-deep descriptor slot; valid clears when i_pkt_descriptor_ready is high; new descriptor and acceptance in the same cycle are both honoured.
REQ-012 SHALL, on byte 2049 of a frame, stop writing, pulse o_pkt_bufid_free_wr with the frame's bufid, enter DISC, and issue no descriptor.
REQ-013 SHALL increment the drop count once per frame dropped by REQ-008 or REQ-012; counters wrap at 16'hFFFF.
REQ-014 SHALL accept a new frame only after at least 2 i_data_wr-low cycles (GMII IFG guarantees this).

Reset
REQ-015 SHALL, on i_rst_n low, clear all outputs to 0, FSM to IDLE, drop held bufid, empty descriptor slot, zero counters; partial frame abandoned without a free pulse.
REQ-016 SHALL, after reset release, ignore a frame already in progress (i_data_wr high) until it ends.

Configuration
REQ-017 SHALL, with CONTROL_RX_DEBUG_EN defined, implement ov_debug_rx_cnt and ov_debug_drop_cnt; without it, keep both ports tied to 16'd0 and remove the counters.

Structure
REQ-018 SHALL place word-type codes (01/00/10/11), FSM encodings and MAX_WORDS in shared package control_rx_pkg.
REQ-019 SHALL implement byte-to-word packing in one sub-module control_rx_byte_pack; FSM, bufid and descriptor logic in the top.

Verification
REQ-020 64-byte frame 0x00..0x3F, bufid 9'h05 held -> 4 writes to 0x0280..0x0283, headers 01/00/00/10, [131:128]=0, descriptor {INPORT,9'h05}.
REQ-021 17-byte frame -> 2 writes: header 01 full word, header 10 with [131:128]=15 and byte 0x10 at [127:120].
REQ-022 10-byte frame -> 1 write, [133:128]=6'b11_0110.
REQ-023 frame start with no held bufid -> no writes, no descriptor, drop count +1.
REQ-024 2100-byte frame -> 128 writes, free pulse with bufid, no descriptor, drop count +1.
REQ-025 descriptor ready held low, second frame arrives -> second frame dropped; first descriptor stays valid until ready.
